// File: rtl/aes_block_loader.sv
// Plaintext staging for the AES datapath: packs 32-bit words into 128-bit blocks,
// queues them in a small FIFO and tracks the last delivered block and a delivery count.
module aes_block_loader #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_block,
    output logic [127:0]      state,
    output logic [CNT_W-1:0]  blk_count,
    output logic              err_frame
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]       idx_q, idx_d;
    logic [95:0]      asm_q, asm_d;
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [127:0]     mem_q [DEPTH];
    logic [127:0]     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic             fifo_empty, fifo_full;
    logic             accept, at_last_idx, push, pop, frame_err;
    logic [127:0]     push_block;

    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Only the final word of a block needs FIFO space; earlier words always fit.
    assign in_ready    = (idx_q != 2'd3) || !fifo_full;
    assign accept      = in_valid && in_ready;
    assign at_last_idx = (idx_q == 2'd3);
    assign push        = accept && at_last_idx && in_last;
    assign frame_err   = accept && (in_last != at_last_idx);
    assign push_block  = {asm_q, in_word};

    assign out_valid   = !fifo_empty;
    assign out_block   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign pop         = out_valid && out_ready;

    assign state       = state_q;
    assign blk_count   = cnt_q;
    assign err_frame   = err_q;

    always_comb begin
        idx_d = idx_q;
        asm_d = asm_q;
        if (accept) begin
            if (in_last || at_last_idx) begin
                idx_d = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
                case (idx_q)
                    2'd0:    asm_d[95:64] = in_word;
                    2'd1:    asm_d[63:32] = in_word;
                    2'd2:    asm_d[31:0]  = in_word;
                    default: ;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
                    mem_q[gi] <= push_block;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            asm_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                state_q  <= out_block;
                cnt_q    <= cnt_q + 1'b1;
            end
            if (frame_err) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Randomised and directed bench for aes_block_loader, checked every cycle
// against a queue-based model of word packing, block FIFO and delivery.
module tb_aes_block_loader;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    bit                clk_en = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_word = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [127:0]      out_block;
    logic [127:0]      state;
    logic [CNT_W-1:0]  blk_count;
    logic              err_frame;

    aes_block_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .state(state), .blk_count(blk_count), .err_frame(err_frame)
    );

    always #5 if (clk_en) clk = ~clk;

    // Reference model: pending words, queued blocks, delivered state.
    logic [31:0]      m_part [$];
    logic [127:0]     m_fifo [$];
    logic [127:0]     m_state;
    logic [CNT_W-1:0] m_cnt;
    logic             m_err;
    bit               last_acc;
    int               n_vec = 0;
    int               n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_part.size() != 3) || (m_fifo.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_part.delete();
        m_fifo.delete();
        m_state = '0;
        m_cnt   = '0;
        m_err   = 1'b0;
    endtask

    task automatic check_all();
        chk("in_ready",  128'(in_ready),  128'(m_ready()));
        chk("out_valid", 128'(out_valid), 128'(m_fifo.size() != 0));
        chk("out_block", out_block, (m_fifo.size() != 0) ? m_fifo[0] : 128'h0);
        chk("state",     state, m_state);
        chk("blk_count", 128'(blk_count), 128'(m_cnt));
        chk("err_frame", 128'(err_frame), 128'(m_err));
    endtask

    // Called at a falling edge; drives inputs, advances one clock, checks at next falling edge.
    task automatic cycle(input logic v, input logic [31:0] w, input logic l, input logic ordy);
        bit acc, pop;
        in_valid = v; in_word = w; in_last = l; out_ready = ordy;
        acc = v && m_ready();
        pop = (m_fifo.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (pop) begin
            m_state = m_fifo.pop_front();
            m_cnt   = m_cnt + 1'b1;
            $display("block delivered %h count %0d", m_state, m_cnt);
        end
        if (acc) begin
            if (l) begin
                if (m_part.size() == 3) m_fifo.push_back({m_part[0], m_part[1], m_part[2], w});
                else m_err = 1'b1;
                m_part.delete();
            end else if (m_part.size() == 3) begin
                m_err = 1'b1;
                m_part.delete();
            end else begin
                m_part.push_back(w);
            end
        end
        last_acc = acc;
        @(negedge clk);
        check_all();
    endtask

    task automatic send_word(input logic [31:0] w, input logic l, input logic ordy);
        int n = 0;
        do begin
            cycle(1'b1, w, l, ordy);
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic send_block(input logic [127:0] b, input logic ordy);
        for (int i = 0; i < 4; i++) begin
            logic [127:0] t;
            t = b >> (32 * (3 - i));
            send_word(t[31:0], i == 3, ordy);
        end
    endtask

    task automatic pulse_rst();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [127:0] blk;
        model_reset();

        // Asynchronous reset with the clock stopped
        #2 rst = 1'b1;
        #1 check_all();
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Single block, known vector
        send_block(128'h3243f6a8_885a308d_313198a2_e0370734, 1'b1);
        chk("t2_valid", 128'(out_valid), 128'(1));
        chk("t2_block", out_block, 128'h3243f6a8_885a308d_313198a2_e0370734);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_state", state, 128'h3243f6a8_885a308d_313198a2_e0370734);
        chk("t2_count", 128'(blk_count), 128'(1));

        // Backpressure: two blocks fill the FIFO, third stalls at its last word
        pulse_rst();
        send_block(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0);
        send_block(128'h0, 1'b0);
        for (int i = 0; i < 3; i++) send_word(32'h0, 1'b0, 1'b0);
        chk("t3_ready_low", 128'(in_ready), 128'(0));
        cycle(1'b1, 32'h1, 1'b1, 1'b0);
        chk("t3_still_low", 128'(in_ready), 128'(0));
        send_word(32'h1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t3_state", state, 128'h1);
        chk("t3_count", 128'(blk_count), 128'(3));

        // Framing error on the second word
        pulse_rst();
        send_word(32'hdeadbeef, 1'b0, 1'b1);
        send_word(32'hcafef00d, 1'b1, 1'b1);
        chk("t4_err", 128'(err_frame), 128'(1));
        chk("t4_nopush", 128'(out_valid), 128'(0));
        send_block(128'h01234567_89abcdef_fedcba98_76543210, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t4_state", state, 128'h01234567_89abcdef_fedcba98_76543210);
        chk("t4_err_sticky", 128'(err_frame), 128'(1));

        // Reset in the middle of a block
        pulse_rst();
        send_word(32'haaaaaaaa, 1'b0, 1'b1);
        send_word(32'hbbbbbbbb, 1'b0, 1'b1);
        pulse_rst();
        chk("t5_count", 128'(blk_count), 128'(0));
        send_block(128'h11111111_22222222_33333333_44444444, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5_state", state, 128'h11111111_22222222_33333333_44444444);
        chk("t5_count1", 128'(blk_count), 128'(1));

        // Counter wrap after 16 deliveries
        pulse_rst();
        blk = '0;
        for (int b = 0; b < 16; b++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            send_block(blk, 1'b1);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_wrap", 128'(blk_count), 128'(0));
        chk("t6_state", state, blk);

        // Random traffic with occasional framing errors and backpressure
        pulse_rst();
        for (int i = 0; i < 400; i++) begin
            logic v, l, r;
            v = ($urandom_range(0, 3) != 0);
            l = (m_part.size() == 3) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 2) != 0);
            cycle(v, $urandom, l, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_block_loader.md
# aes_block_loader

Input staging block for the AES datapath. It accepts plaintext as a stream of 32-bit words and assembles each group of four words into a 128-bit block. Assembled blocks are buffered in a small FIFO and handed to the AES core over a valid/ready handshake. Each delivered block is also published on a registered `state` bus, which the downstream trigger/monitor logic compares against fixed block patterns.

## Interface
- `DEPTH`, default 2: number of 128-bit block entries in the FIFO. Must be a power of 2 and at least 2.
- `CNT_W`, default 32: width of the delivered-block counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  loader can accept a word this cycle.
- `in_word`  in  32  plaintext word. The first word of a block maps to bits [127:96].
- `in_last`  in  1  marks the 4th word of a block.
- `out_valid`  out  1  `out_block` is valid. Driven from FIFO head.
- `out_ready`  in  1  AES core accepts `out_block`.
- `out_block`  out  128  FIFO head block.
- `state`  out  128  last block delivered (registered copy).
- `blk_count`  out  CNT_W  number of blocks delivered, modulo 2^CNT_W.
- `err_frame`  out  1  sticky framing-error flag.

## Operation
- **Word accept:** a word is accepted when `in_valid && in_ready`.
- **Word index `idx`:** 2-bit counter in the range 0..3. It increments on each accepted word.
- **Assembly register:**
  - idx 0 writes [127:96].
  - idx 1 writes [95:64].
  - idx 2 writes [63:32].
  - idx 3 writes [31:0].
- **Block completion:** accept at idx 3 with `in_last=1`. The full 128-bit word (assembly bits [127:32] plus `in_word`) is pushed into the FIFO and `idx` goes to 0.
- **Framing errors:**
  - Accept with `in_last=1` at idx < 3: the partial block is discarded, `idx` goes to 0 and `err_frame` is set. The word itself is dropped.
  - Accept with `in_last=0` at idx 3: the assembled block is discarded (no push), `idx` goes to 0 and `err_frame` is set.
  - `err_frame` clears only on `rst`.
- **`in_ready`:** equals `(idx != 3) || !fifo_full`. There is no combinational path from `out_ready`.
- **FIFO:**
  - Circular buffer with read/write pointers of width log2(DEPTH)+1. The extra MSB distinguishes full from empty.
  - Push and pop in the same cycle are allowed when the FIFO is not full. Occupancy is then unchanged.
  - A push into a full FIFO cannot occur, because `in_ready` is low.
- **Output:** `out_valid = !fifo_empty` and `out_block` is the head entry. Both are stable while `out_valid && !out_ready`.
- **Delivery:** a block is delivered on `out_valid && out_ready`. On that edge:
  - the head is popped;
  - `state` is loaded with the head value;
  - `blk_count` increments, wrapping from 2^CNT_W−1 to 0.
- **Reset values (asynchronous):**
  - `idx=0`, FIFO empty, assembly register 0.
  - `out_valid=0`, `out_block=0` (empty head reads as 0).
  - `state=128'h0`, `blk_count=0`, `err_frame=0`.
  - `in_ready=1`.
- **Reset mid-operation:** any partial block and all FIFO contents are lost. Nothing is delivered afterwards until four new words have been accepted.

## Timing
- **Latency:** if the 4th word is accepted at edge N and the FIFO was empty, `out_valid=1` in the cycle after edge N. With `out_ready=1`, delivery occurs at edge N+1, and `state` and `blk_count` update after edge N+1.
- **Throughput:** 1 word per cycle while the FIFO is not full, which gives one block per 4 cycles sustained.
- **Backpressure:** with the FIFO full, `in_ready` deasserts only while `idx=3`. Words at idx 0..2 are still accepted into the assembly register.
- **Full FIFO and simultaneous pop:** if the FIFO is full and a pop occurs at edge M, `in_ready` rises in the cycle after M. There is no same-cycle bypass.
- **`state` hold:** `state` changes only on delivery edges. It holds its value through idle periods and through framing errors.

## Test plan
1. **Reset values.** Assert `rst` asynchronously with no clock running. Required: all outputs at their reset values immediately, `in_ready=1`.
2. **Single block.** With `out_ready=1`, send words 3243f6a8, 885a308d, 313198a2, e0370734 (`in_last` on the 4th). Required: `out_valid` high one cycle after the 4th accept with `out_block=128'h3243f6a8_885a308d_313198a2_e0370734`. After that edge, `state` equals this block and `blk_count=1`.
3. **Backpressure (DEPTH=2).** Hold `out_ready=0` and stream three blocks: 00112233.., 0, 1. Required: `in_ready` drops at idx 3 of the third block. Then release `out_ready`. Required: blocks are delivered in order, `in_ready` rises one cycle after the first pop, and the final values are `state=128'h1` and `blk_count=3`.
4. **Framing error.** Assert `in_last` on the 2nd word. Required: `err_frame=1`, no push, `idx=0`. Then send a valid 4-word block. Required: it is delivered correctly and `err_frame` stays 1.
5. **Reset mid-block.** Accept 2 words, then pulse `rst`. Required: no block delivered and `blk_count=0`. The next 4 words form the first block.
6. **Counter wrap (CNT_W=4).** Deliver 16 blocks. Required: `blk_count` returns to 0 and `state` equals the 16th block.
